// File: rtl/complex_gate_sched_pkg.sv
// Shared constants and the A&(B|C) gate function used by the scheduler and its bench.
// Purely combinational helpers; no state.
package complex_gate_pkg;
  localparam int NREQ_D   = 4;
  localparam int WIDTH_D  = 8;
  localparam int LAT_D    = 2;
  localparam int ABC_MAXW = 64;

  // Callers zero-extend operands to ABC_MAXW and truncate the result to their width.
  function automatic logic [ABC_MAXW-1:0] abc_eval(input logic [ABC_MAXW-1:0] a,
                                                   input logic [ABC_MAXW-1:0] b,
                                                   input logic [ABC_MAXW-1:0] c);
    return a & (b | c);
  endfunction
endpackage

// File: rtl/complex_gate_sched_if.sv
// Requester-side bundle of the shared gate scheduler.
// master = requesters, slave = scheduler.
interface complex_gate_sched_if
  import complex_gate_pkg::*;
#(
  parameter int NREQ  = NREQ_D,
  parameter int WIDTH = WIDTH_D
);
  logic                  en;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*WIDTH-1:0] req_c;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic [NREQ-1:0]       busy;

  modport master (
    output en, req_valid, req_a, req_b, req_c,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  en, req_valid, req_a, req_b, req_c,
    output req_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/complex_gate_sched_eval.sv
// LAT-stage A&(B|C) pipeline tagged with requester index; result formed in stage 0.
// Latency LAT cycles, one entry per cycle, never stalls.
module complex_gate_eval
  import complex_gate_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int LAT   = LAT_D,
  parameter int IDXW  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IDXW-1:0]  in_idx,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  output logic [IDXW-1:0]  out_idx,
  output logic [WIDTH-1:0] out_data
);
  logic [LAT-1:0]   vld_q;
  logic [IDXW-1:0]  idx_q [LAT];
  logic [WIDTH-1:0] dat_q [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int s = 0; s < LAT; s++) begin
        idx_q[s] <= '0;
        dat_q[s] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid;
      idx_q[0] <= in_idx;
      dat_q[0] <= WIDTH'(abc_eval(ABC_MAXW'(a), ABC_MAXW'(b), ABC_MAXW'(c)));
      for (int s = 1; s < LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        idx_q[s] <= idx_q[s-1];
        dat_q[s] <= dat_q[s-1];
      end
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_idx   = idx_q[LAT-1];
  assign out_data  = dat_q[LAT-1];
endmodule

// File: rtl/complex_gate_sched.sv
// Round-robin arbiter sharing one A&(B|C) pipeline among NREQ requesters; result after LAT cycles.
// A requester is held off (req_ready low) while its result is in flight or when en is low.
module complex_gate_sched
  import complex_gate_pkg::*;
#(
  parameter int NREQ  = NREQ_D,
  parameter int WIDTH = WIDTH_D,
  parameter int LAT   = LAT_D
) (
  input  logic                 clk,
  input  logic                 rst_n,
  complex_gate_sched_if.slave  bus
);
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDXW-1:0]  ptr_q;
  logic [IDXW-1:0]  gnt_idx;
  logic             gnt_any;
  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  busy_q;
  logic [NREQ-1:0]  rsp_vec;
  logic             ev_vld;
  logic [IDXW-1:0]  ev_idx;
  logic [WIDTH-1:0] ev_dat;
  logic [WIDTH-1:0] dat_q;

  // rst_n in the term keeps req_ready low for the whole reset, not just after the first edge.
  assign elig = bus.req_valid & ~busy_q & {NREQ{bus.en & rst_n}};

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any && elig[(int'(ptr_q) + k) % NREQ]) begin
        gnt_any = 1'b1;
        gnt_idx = IDXW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  assign bus.req_ready = gnt_any ? (NREQ'(1) << gnt_idx) : '0;

  always_comb begin
    rsp_vec = '0;
    if (ev_vld) rsp_vec[ev_idx] = 1'b1;
  end

  // A responding requester is still busy this cycle, so it cannot be re-granted until the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      busy_q <= '0;
      dat_q  <= '0;
    end else begin
      if (gnt_any) ptr_q <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
      busy_q <= (busy_q & ~rsp_vec) | bus.req_ready;
      if (ev_vld) dat_q <= ev_dat;
    end
  end

  complex_gate_eval #(
    .WIDTH (WIDTH),
    .LAT   (LAT),
    .IDXW  (IDXW)
  ) u_eval (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (gnt_any),
    .in_idx    (gnt_idx),
    .a         (bus.req_a[gnt_idx*WIDTH +: WIDTH]),
    .b         (bus.req_b[gnt_idx*WIDTH +: WIDTH]),
    .c         (bus.req_c[gnt_idx*WIDTH +: WIDTH]),
    .out_valid (ev_vld),
    .out_idx   (ev_idx),
    .out_data  (ev_dat)
  );

  assign bus.rsp_valid = rsp_vec;
  assign bus.rsp_data  = ev_vld ? ev_dat : dat_q;
  assign bus.busy      = busy_q;
endmodule
